st_system_tx_engine: RTL and testbench
======================================

// Module: st_system_tx_engine
// PURPOSE
//  Parametrised serial transmit engine: latches a DATA_W-bit word, runs an RTS/ACK request handshake,
//  then shifts the word (plus optional parity) out on sdo with a generated sclk.
//  Successor to the fixed-width STSystem transmit FSM. Adds width/divider/bit-order/parity generics,
//  txe pause, ack timeout and abort. Sits between the parallel data source and the serial line driver.
// PARAMETERS
//  DATA_W       8    payload width in bits, >=1
//  CLK_DIV      4    clk cycles per serial bit; even, >=2; sclk low first half, high second half
//  MSB_FIRST    1    1: data_in[DATA_W-1] sent first; 0: data_in[0] first
//  PARITY_EN    1    1: append one parity bit after the payload
//  PARITY_ODD   0    0: even parity; 1: odd parity (ignored if PARITY_EN=0)
//  ACK_TIMEOUT  255  max cycles waiting for ack in REQ; 0 disables timeout
// PORTS
//  clk      in   1       system clock, all logic on posedge
//  rst      in   1       synchronous reset, active-low
//  send     in   1       start request; sampled only in IDLE
//  data_in  in   DATA_W  word to transmit; captured in LATCH
//  txe      in   1       transmit enable; 0 freezes shifting
//  ack      in   1       receiver acknowledge of rts
//  ld       out  1       1-cycle strobe when data_in is captured
//  rts      out  1       request to send
//  sclk     out  1       serial clock
//  sdo      out  1       serial data; idles high
//  busy     out  1       1 in any state other than IDLE
//  done     out  1       1-cycle pulse on successful frame end
//  err      out  1       1-cycle pulse on timeout or abort
// BEHAVIOUR
//  Reset (rst=0 at posedge): state=IDLE; ld=0, rts=0, sclk=0, sdo=1, busy=0, done=0, err=0; counters cleared.
//  Reset mid-frame aborts immediately with no done/err pulse.
//  Frame length NB = DATA_W + PARITY_EN. Parity = XOR(data) ^ PARITY_ODD, computed on the latched word.
//  States:
//   IDLE:    send=1 -> LATCH.
//   LATCH:   ld=1, shift reg <= data_in, parity bit computed; always -> REQ.
//   REQ:     rts=1. ack=1 -> SHIFT. Timeout counter increments each cycle;
//            reaching ACK_TIMEOUT -> err pulse and IDLE.
//   SHIFT:   rts=1. sdo = current bit. Bit timer counts 0..CLK_DIV-1; sclk = (timer >= CLK_DIV/2).
//            At timer=CLK_DIV-1: advance to the next bit. After bit NB-1 -> RELEASE.
//            txe=0 holds the timer, sclk and sdo unchanged.
//            ack=0 in SHIFT -> abort: err pulse, sdo=1, sclk=0, next state IDLE.
//   RELEASE: rts=0, sdo=1, sclk=0. ack=0 -> IDLE with done=1 on that transition cycle.
//            ack stuck high here uses the same ACK_TIMEOUT -> err.
//  Latency (ack already high, txe=1): send sampled at T0; ld at T1; rts rises at T2;
//   first bit on sdo at T3; SHIFT lasts NB*CLK_DIV cycles.
//  Signals do not change between REQ and SHIFT apart from the shift itself.
//  send while busy=1 is ignored and not queued.
//  done and err are never asserted in the same cycle.
//  Timeout counter width: $clog2(ACK_TIMEOUT+1); cleared on every state entry.
//  Bit counter width: $clog2(NB+1).
// STRUCTURE
//  Shared package srt_pkg: state encodings (IDLE, LATCH, REQ, SHIFT, RELEASE as 3-bit localparams)
//   and a parity function reused by the receive side.
//  One sub-module, st_bit_timer (CLK_DIV counter with hold input, bit_end strobe and sclk output).
//  FSM, shift register and timeout counter stay in this module.
// TESTING (DATA_W=8, CLK_DIV=4, MSB_FIRST=1, PARITY_EN=1, PARITY_ODD=0, ACK_TIMEOUT=16)
//  1. send=1 with data_in=8'hA5 and ack responding 2 cycles after rts ->
//     sdo bits 1,0,1,0,0,1,0,1 then parity 0, 36 SHIFT cycles, 9 sclk rising edges, done=1 once.
//  2. PARITY_ODD=1 and MSB_FIRST=0 with data_in=8'h01 -> sdo bits 1,0,0,0,0,0,0,0 then parity 0.
//  3. ack never asserted -> rts high for 16 cycles, then err=1 for 1 cycle, IDLE, sdo=1, no done.
//  4. txe=0 for 10 cycles during bit 3 -> sclk/sdo frozen; frame lengthens to exactly 46 SHIFT cycles; data intact.
//  5. ack dropped during bit 5 -> err pulse next cycle, rts=0, sdo=1; a later send transmits a correct fresh frame.
//  6. rst=0 mid-SHIFT -> all outputs at reset values after that edge; send held during the frame is ignored.

Source files
------------

// File: rtl/srt_pkg.sv
// Shared definitions for the serial request/transmit path: state encodings and
// the parity rule used by both the transmit engine and the receive side.
package srt_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LATCH   = 3'd1;
  localparam logic [2:0] ST_REQ     = 3'd2;
  localparam logic [2:0] ST_SHIFT   = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_LATCH   = ST_LATCH,
    S_REQ     = ST_REQ,
    S_SHIFT   = ST_SHIFT,
    S_RELEASE = ST_RELEASE
  } state_t;

  localparam int PAR_MAX_W = 64;

  // Callers zero-extend their word; the extra zeros do not change the XOR.
  function automatic logic parity_bit(input logic [PAR_MAX_W-1:0] word, input logic odd);
    return (^word) ^ odd;
  endfunction

endpackage

// File: rtl/st_bit_timer.sv
// Per-bit timer: counts 0..CLK_DIV-1 while run is high, freezes on hold,
// drives sclk low for the first half of a bit and high for the second.
module st_bit_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic hold,
  output logic sclk,
  output logic bit_end
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(CLK_DIV / 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!run)            cnt_d = '0;
    else if (hold)       cnt_d = cnt_q;
    else if (cnt_q == LAST) cnt_d = '0;
    else                 cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign bit_end = run & ~hold & (cnt_q == LAST);
  assign sclk    = run & (cnt_q >= HALF);

endmodule

// File: rtl/st_system_tx_engine.sv
// Serial transmit engine: latch a word, request the line with rts/ack,
// then shift the word plus optional parity out on sdo under a generated sclk.
module st_system_tx_engine #(
  parameter int DATA_W      = 8,
  parameter int CLK_DIV     = 4,
  parameter int MSB_FIRST   = 1,
  parameter int PARITY_EN   = 1,
  parameter int PARITY_ODD  = 0,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              send,
  input  logic [DATA_W-1:0] data_in,
  input  logic              txe,
  input  logic              ack,
  output logic              ld,
  output logic              rts,
  output logic              sclk,
  output logic              sdo,
  output logic              busy,
  output logic              done,
  output logic              err
);
  import srt_pkg::*;

  // Handshake: rts is held from REQ through the last bit; the receiver must keep
  // ack high for the whole shift and drop it after rts falls to close the frame.

  localparam int NB   = DATA_W + ((PARITY_EN != 0) ? 1 : 0);
  localparam int BC_W = $clog2(NB + 1);
  localparam int TO_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(NB - 1);

  state_t            state_q, state_d;
  logic [NB-1:0]     frame_q, frame_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              ld_q, ld_d, rts_q, rts_d, sdo_q, sdo_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic              bit_end, timeout_hit, par;

  st_bit_timer #(.CLK_DIV(CLK_DIV)) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .run     (state_q == S_SHIFT),
    .hold    (~txe),
    .sclk    (sclk),
    .bit_end (bit_end)
  );

  assign timeout_hit = (ACK_TIMEOUT != 0) && (to_q == TO_LAST);
  assign par         = parity_bit(PAR_MAX_W'(data_in), PARITY_ODD != 0);

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    bit_cnt_d = bit_cnt_q;
    to_d      = to_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: if (send) state_d = S_LATCH;
      S_LATCH: begin
        // Frame is stored in send order with the first bit at the top.
        for (int i = 0; i < DATA_W; i++)
          frame_d[NB-1-i] = (MSB_FIRST != 0) ? data_in[DATA_W-1-i] : data_in[i];
        if (PARITY_EN != 0) frame_d[0] = par;
        bit_cnt_d = '0;
        state_d   = S_REQ;
      end
      S_REQ: begin
        if (ack) state_d = S_SHIFT;
        else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else to_d = to_q + 1'b1;
      end
      S_SHIFT: begin
        if (!ack) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (bit_end) begin
          frame_d = frame_q << 1;
          if (bit_cnt_q == BC_LAST) state_d = S_RELEASE;
          else bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      S_RELEASE: begin
        if (!ack) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else to_d = to_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) to_d = '0;

    // Outputs are registered from the next state so they line up with it.
    ld_d   = (state_d == S_LATCH);
    rts_d  = (state_d == S_REQ) || (state_d == S_SHIFT);
    busy_d = (state_d != S_IDLE);
    sdo_d  = (state_d == S_SHIFT) ? frame_d[NB-1] : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      frame_q   <= '0;
      bit_cnt_q <= '0;
      to_q      <= '0;
      ld_q      <= 1'b0;
      rts_q     <= 1'b0;
      sdo_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      bit_cnt_q <= bit_cnt_d;
      to_q      <= to_d;
      ld_q      <= ld_d;
      rts_q     <= rts_d;
      sdo_q     <= sdo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign ld   = ld_q;
  assign rts  = rts_q;
  assign sdo  = sdo_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_st_system_tx_engine.sv
// Bench for st_system_tx_engine: randomized frames, an ack responder, and a
// monitor that pops expected frame events from a queue as done/err appear.
module tb_st_system_tx_engine;

  localparam int W = 24;  // [23:16] shift cycles, [15] err event, [8:0] frame bits

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       send = 1'b0, txe = 1'b1, ack = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       ld, rts, sclk, sdo, busy, done, err;

  logic       send2 = 1'b0, ack2 = 1'b0;
  logic [7:0] data2 = 8'h00;
  logic       ld2, rts2, sclk2, sdo2, busy2, done2, err2;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic ack_on = 1'b1;
  int done_seen = 0;
  int done_exp = 0;

  st_system_tx_engine #(.DATA_W(8), .CLK_DIV(4), .MSB_FIRST(1), .PARITY_EN(1),
                        .PARITY_ODD(0), .ACK_TIMEOUT(16)) u_dut (
    .clk(clk), .rst(rst), .send(send), .data_in(data_in), .txe(txe), .ack(ack),
    .ld(ld), .rts(rts), .sclk(sclk), .sdo(sdo), .busy(busy), .done(done), .err(err)
  );

  st_system_tx_engine #(.DATA_W(8), .CLK_DIV(4), .MSB_FIRST(0), .PARITY_EN(1),
                        .PARITY_ODD(1), .ACK_TIMEOUT(16)) u_dut_lsb (
    .clk(clk), .rst(rst), .send(send2), .data_in(data2), .txe(txe), .ack(ack2),
    .ld(ld2), .rts(rts2), .sclk(sclk2), .sdo(sdo2), .busy(busy2), .done(done2), .err(err2)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference frame: payload MSB first followed by even parity.
  function automatic logic [8:0] model_frame(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += d[i];
    return {d, 1'(ones % 2)};
  endfunction

  // ---------------- ack responder ----------------
  initial begin
    int rts_cnt = 0;
    forever begin
      @(posedge clk);
      #2;
      if (ack_on && rts) begin
        rts_cnt++;
        if (rts_cnt >= 2) ack = 1'b1;
      end else begin
        rts_cnt = 0;
        ack = 1'b0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [8:0]   bits;
    int           rises;
    int           sc;
    logic         sclk_p;
    logic [W-1:0] e;
    bits = '0; rises = 0; sc = 0; sclk_p = 1'b0;
    forever begin
      tick();
      if (!rst) begin
        bits = '0; rises = 0; sc = 0; sclk_p = 1'b0;
      end else begin
        if (ld) begin bits = '0; rises = 0; sc = 0; end
        if (rts && ack) sc++;
        if (sclk && !sclk_p) begin
          bits = {bits[7:0], sdo};
          rises++;
        end
        sclk_p = sclk;
        if (done || err) begin
          check("done_err_exclusive", 32'(done & err), 0);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event done=%0b err=%0b", done, err);
          end else begin
            e = exp_q.pop_front();
            check("event_kind_err", 32'(err), 32'(e[15]));
            if (done) begin
              done_seen++;
              check("frame_bits", 32'(bits), 32'(e[8:0]));
              check("sclk_rises", rises, 9);
              check("shift_cycles", sc, 32'(e[23:16]));
            end
          end
          bits = '0; rises = 0; sc = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; send = 1'b0; send2 = 1'b0; txe = 1'b1;
    repeat (3) tick();
    check("reset_outputs", 32'({ld, rts, sclk, sdo, busy, done, err}), 32'(7'b0001000));
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input int pause_len, input bit chk_lat);
    int  sc = 0;
    bit  paused = 1'b0;
    bit  fin = 1'b0;
    logic [1:0] snap;
    exp_q.push_back({8'(36 + pause_len), 1'b0, 6'b0, model_frame(d)});
    done_exp++;
    @(negedge clk);
    data_in = d; send = 1'b1;
    tick();
    if (chk_lat) check("ld_strobe", 32'({ld, busy, rts}), 32'(3'b110));
    @(negedge clk);
    send = 1'b0;
    tick();
    if (chk_lat) check("rts_rise", 32'({ld, rts, sdo}), 32'(3'b011));
    @(negedge clk);
    data_in = ~d;
    for (int n = 0; n < 300 && !fin; n++) begin
      tick();
      if (rts && ack) sc++;
      if (pause_len > 0 && sc == 13 && !paused) begin
        paused = 1'b1;
        snap = {sclk, sdo};
        @(negedge clk);
        txe = 1'b0;
        for (int k = 0; k < pause_len; k++) begin
          tick();
          check("pause_frozen", 32'({sclk, sdo}), 32'(snap));
        end
        @(negedge clk);
        txe = 1'b1;
      end
      if (!busy) fin = 1'b1;
    end
    check("frame_finished", 32'(fin), 1);
    check("idle_after_frame", 32'({rts, sdo, sclk}), 32'(3'b010));
  endtask

  task automatic timeout_frame();
    int rcnt = 0;
    bit got_err = 1'b0;
    exp_q.push_back({8'd0, 1'b1, 15'd0});
    ack_on = 1'b0;
    @(negedge clk);
    data_in = 8'($urandom_range(0, 255)); send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    for (int n = 0; n < 100 && !got_err; n++) begin
      tick();
      if (rts) rcnt++;
      if (err) got_err = 1'b1;
    end
    check("timeout_err_seen", 32'(got_err), 1);
    check("timeout_rts_cycles", rcnt, 16);
    check("timeout_outputs", 32'({rts, sdo, busy, done}), 32'(4'b0100));
    tick();
    check("timeout_err_pulse", 32'({err, busy}), 0);
    @(negedge clk);
    ack_on = 1'b1;
  endtask

  task automatic abort_frame();
    int sc = 0;
    bit got_err = 1'b0;
    exp_q.push_back({8'd0, 1'b1, 15'd0});
    @(negedge clk);
    data_in = 8'($urandom_range(0, 255)); send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    for (int n = 0; n < 100 && sc < 21; n++) begin
      tick();
      if (rts && ack) sc++;
    end
    check("abort_reached_bit5", sc, 21);
    @(negedge clk);
    ack_on = 1'b0;
    for (int n = 0; n < 20 && !got_err; n++) begin
      tick();
      if (err) got_err = 1'b1;
    end
    check("abort_err_seen", 32'(got_err), 1);
    check("abort_outputs", 32'({rts, sdo, sclk, busy, done}), 32'(5'b01000));
    @(negedge clk);
    ack_on = 1'b1;
  endtask

  task automatic reset_mid_frame();
    int sc = 0;
    int ldc = 0;
    @(negedge clk);
    data_in = 8'($urandom_range(0, 255)); send = 1'b1;
    for (int n = 0; n < 100 && sc < 10; n++) begin
      tick();
      if (ld) ldc++;
      if (rts && ack) sc++;
    end
    check("held_send_single_ld", ldc, 1);
    check("reset_reached_shift", sc, 10);
    @(negedge clk);
    send = 1'b0; rst = 1'b0;
    tick();
    check("midframe_reset_outputs", 32'({ld, rts, sclk, sdo, busy, done, err}), 32'(7'b0001000));
    @(negedge clk);
    rst = 1'b1;
    repeat (5) tick();
    check("post_reset_idle", 32'({busy, done, err, ld}), 0);
  endtask

  task automatic lsb_frame(input logic [7:0] d);
    logic [8:0] got, want;
    int   rises;
    logic sp;
    bit   fin, saw_err;
    int   ones;
    got = '0; rises = 0; sp = 1'b0; fin = 1'b0; saw_err = 1'b0; ones = 0;
    for (int i = 0; i < 8; i++) begin
      want[8-i] = d[i];
      ones += d[i];
    end
    want[0] = 1'((ones + 1) % 2);
    @(negedge clk);
    data2 = d; send2 = 1'b1;
    @(negedge clk);
    send2 = 1'b0;
    for (int n = 0; n < 200 && !fin; n++) begin
      tick();
      if (sclk2 && !sp) begin
        got = {got[7:0], sdo2};
        rises++;
      end
      sp = sclk2;
      if (err2) saw_err = 1'b1;
      if (done2) fin = 1'b1;
      @(negedge clk);
      ack2 = rts2;
    end
    check("lsb_done", 32'(fin), 1);
    check("lsb_no_err", 32'(saw_err), 0);
    check("lsb_bits", 32'(got), 32'(want));
    check("lsb_rises", rises, 9);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    do_reset();
    send_frame(8'hA5, 0, 1'b1);
    for (int i = 0; i < 6; i++) send_frame(8'($urandom_range(0, 255)), 0, 1'b0);
    send_frame(8'($urandom_range(0, 255)), 10, 1'b0);
    for (int i = 0; i < 3; i++) send_frame(8'($urandom_range(0, 255)), $urandom_range(1, 5), 1'b0);
    timeout_frame();
    abort_frame();
    send_frame(8'($urandom_range(0, 255)), 0, 1'b0);
    reset_mid_frame();
    send_frame(8'($urandom_range(0, 255)), 0, 1'b0);
    lsb_frame(8'h01);
    lsb_frame(8'($urandom_range(0, 255)));
    lsb_frame(8'($urandom_range(0, 255)));
    repeat (4) tick();
    check("queue_empty", exp_q.size(), 0);
    check("done_count", done_seen, done_exp);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
